// File: rtl/onehot_decoder_pkg.sv
// rtl/onehot_decoder_pkg.sv - shared state and mode encodings for the one-hot scan decoder
package onehot_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_scan_decoder_dwell_timer.sv
// rtl/onehot_scan_decoder_dwell_timer.sv - reloadable dwell down-counter; expire while count is zero
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               hold,
  input  logic [DWELL_W-1:0] load_val,
  output logic               expire
);

  logic [DWELL_W-1:0] cap_q, cap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cap_d = cap_q;
    cnt_d = cnt_q;
    if (load) begin
      cap_d = load_val;
      cnt_d = load_val;
    end else if (!hold) begin
      // expiry reloads the captured dwell so each index lasts dwell+1 cycles
      cnt_d = (cnt_q == '0) ? cap_q : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= '0;
      cnt_q <= '0;
    end else begin
      cap_q <= cap_d;
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/onehot_scan_decoder.sv
// rtl/onehot_scan_decoder.sv - registered one-hot decoder with direct and dwell-timed scan modes
// Scan mode and the dwell timer exist only when ONEHOT_SCAN_DECODER_SCAN_EN is defined.
module onehot_scan_decoder
  import onehot_decoder_pkg::*;
#(
  parameter  int SEL_W      = 3,
  parameter  int DWELL_W    = 8,
  parameter  int ACTIVE_LOW = 1,
  localparam int OUT_W      = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_n,
  input  logic               load,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   dout,
  output logic [SEL_W-1:0]   idx,
  output logic               busy,
  output logic               wrap
);

  localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW != 0}};

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             mode_eff;
  logic             advance;
  logic             wrap_d;

`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
  logic busy_q, wrap_q;
  logic expire;

  assign mode_eff = mode;

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load && (mode == MODE_SCAN)),
    .hold     (load || en_n || (state_q != ST_SCAN)),
    .load_val (dwell),
    .expire   (expire)
  );

  // a same-cycle load wins over expiry, so no advance and no wrap from that cycle
  assign advance = (state_q == ST_SCAN) && !en_n && expire && !load;
  assign busy    = busy_q;
  assign wrap    = wrap_q;
`else
  logic unused_scan_inputs;

  assign unused_scan_inputs = ^{mode, dwell};
  assign mode_eff           = MODE_DIRECT;
  assign advance            = 1'b0;
  assign busy               = 1'b0;
  assign wrap               = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    if (load) begin
      idx_d   = sel;
      state_d = (mode_eff == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
    end else if (advance) begin
      idx_d  = idx_q + 1'b1;
      wrap_d = (idx_q == SEL_W'(OUT_W - 1));
    end
    dout_d = (en_n || (state_d == ST_IDLE)) ? INACTIVE : decode(idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dout_q  <= INACTIVE;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
      busy_q  <= (state_d == ST_SCAN);
      wrap_q  <= wrap_d;
`endif
    end
  end

  assign dout = dout_q;
  assign idx  = idx_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb/tb_onehot_scan_decoder.sv - scoreboard bench for onehot_scan_decoder (scan cases under ONEHOT_SCAN_DECODER_SCAN_EN)
module tb_onehot_scan_decoder;

  logic       clk;
  logic       rst;
  logic       en_n;
  logic       load;
  logic       mode;
  logic [2:0] sel;
  logic [7:0] dwell;
  logic [7:0] dout;
  logic [2:0] idx;
  logic       busy;
  logic       wrap;

  onehot_scan_decoder dut (
    .clk   (clk),
    .rst   (rst),
    .en_n  (en_n),
    .load  (load),
    .mode  (mode),
    .sel   (sel),
    .dwell (dwell),
    .dout  (dout),
    .idx   (idx),
    .busy  (busy),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dout;
    logic [2:0] idx;
    logic       busy;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // reference model state
  int         m_st;  // 0 idle, 1 direct, 2 scan
  logic [2:0] m_idx;
  logic [7:0] m_cnt;
  logic [7:0] m_cap;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic cycle(input logic r, input logic l, input logic m, input logic [2:0] s,
                       input logic [7:0] d, input logic e);
    exp_t x;
    logic m_eff;
    logic [7:0] oh;
    rst = r; load = l; mode = m; sel = s; dwell = d; en_n = e;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    m_eff = m;
`else
    m_eff = 1'b0;
`endif
    x.wrap = 1'b0;
    if (r) begin
      m_st = 0; m_idx = 3'd0; m_cnt = 8'd0; m_cap = 8'd0;
    end else if (l) begin
      m_idx = s;
      if (m_eff) begin m_st = 2; m_cnt = d; m_cap = d; end
      else m_st = 1;
    end else if (m_st == 2 && !e) begin
      if (m_cnt == 8'd0) begin
        x.wrap = (m_idx == 3'd7);
        m_idx  = m_idx + 3'd1;
        m_cnt  = m_cap;
      end else m_cnt = m_cnt - 8'd1;
    end
    oh     = 8'd1 << m_idx;
    x.dout = (r || e || m_st == 0) ? 8'hFF : ~oh;
    x.idx  = m_idx;
    x.busy = (m_st == 2);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk("dout", dout, x.dout);
    chk("idx",  {5'd0, idx}, {5'd0, x.idx});
    chk("busy", {7'd0, busy}, {7'd0, x.busy});
    chk("wrap", {7'd0, wrap}, {7'd0, x.wrap});
  endtask

  task automatic idle_n(input int n, input logic e);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, e);
  endtask

`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
  int wraps;
`endif

  initial begin
    rst = 1'b1; load = 1'b0; mode = 1'b0; sel = 3'd0; dwell = 8'd0; en_n = 1'b0;
    m_st = 0; m_idx = 3'd0; m_cnt = 8'd0; m_cap = 8'd0;

    // reset defaults
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    chk("rst_dout", dout, 8'hFF);
    chk("rst_idx", {5'd0, idx}, 8'd0);
    idle_n(3, 1'b0);
    chk("idle_dout", dout, 8'hFF);

    // direct select, held for 20 cycles
    cycle(1'b0, 1'b1, 1'b0, 3'd5, 8'd0, 1'b0);
    chk("direct_dout", dout, 8'hDF);
    chk("direct_idx", {5'd0, idx}, 8'd5);
    idle_n(20, 1'b0);
    chk("direct_hold", dout, 8'hDF);

    // output enable gating in direct
    idle_n(3, 1'b1);
    chk("en_off_dout", dout, 8'hFF);
    idle_n(1, 1'b0);
    chk("en_on_dout", dout, 8'hDF);

    // load while disabled, then enable; index boundaries
    cycle(1'b0, 1'b1, 1'b0, 3'd2, 8'd0, 1'b1);
    chk("load_dis_dout", dout, 8'hFF);
    idle_n(1, 1'b0);
    chk("load_dis_en", dout, 8'hFB);
    cycle(1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
    chk("sel0", dout, 8'hFE);
    cycle(1'b0, 1'b1, 1'b0, 3'd7, 8'd0, 1'b0);
    chk("sel7", dout, 8'h7F);

`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    // scan from 6 with dwell 2
    cycle(1'b0, 1'b1, 1'b1, 3'd6, 8'd2, 1'b0);
    chk("scan_busy", {7'd0, busy}, 8'd1);
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
      if (i == 1) chk("scan_i6", {5'd0, idx}, 8'd6);
      if (i == 2) chk("scan_i7", {5'd0, idx}, 8'd7);
      if (i == 5) chk("scan_wrap", {6'd0, wrap, idx == 3'd0}, 8'd3);
      if (wrap) wraps++;
    end
    chk("wrap_count", 8'(wraps), 8'd1);

    // enable freeze with dwell 0
    cycle(1'b0, 1'b1, 1'b1, 3'd1, 8'd0, 1'b0);
    idle_n(2, 1'b0);
    chk("fast_idx", {5'd0, idx}, 8'd3);
    idle_n(4, 1'b1);
    chk("freeze_dout", dout, 8'hFF);
    chk("freeze_idx", {5'd0, idx}, 8'd3);
    idle_n(1, 1'b0);
    chk("resume_idx", {5'd0, idx}, 8'd4);

    // load collides with expiry at idx 7
    cycle(1'b0, 1'b1, 1'b1, 3'd6, 8'd0, 1'b0);
    idle_n(1, 1'b0);
    chk("coll_pre", {5'd0, idx}, 8'd7);
    cycle(1'b0, 1'b1, 1'b0, 3'd2, 8'd0, 1'b0);
    chk("coll_idx", {5'd0, idx}, 8'd2);
    chk("coll_wrap", {7'd0, wrap}, 8'd0);
    chk("coll_busy", {7'd0, busy}, 8'd0);

    // reset mid-scan overrides load
    cycle(1'b0, 1'b1, 1'b1, 3'd4, 8'd1, 1'b0);
    idle_n(3, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 3'd5, 8'd3, 1'b0);
    chk("rst_scan_dout", dout, 8'hFF);
    chk("rst_scan_busy", {7'd0, busy}, 8'd0);
    idle_n(2, 1'b0);
`else
    // scan request without scan support behaves as direct
    cycle(1'b0, 1'b1, 1'b1, 3'd3, 8'd2, 1'b0);
    chk("off_dout", dout, 8'hF7);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
      chk("off_flags", {6'd0, busy, wrap}, 8'd0);
    end
    chk("off_hold", dout, 8'hF7);
    cycle(1'b1, 1'b1, 1'b0, 3'd6, 8'd0, 1'b0);
    chk("rst_load_dout", dout, 8'hFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
